// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader: burst prefetch of 96-bit frame words from SDRAM
// into a first-word-fall-through FIFO feeding the LCD pixel driver.
module lcd_frame_reader #(
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 32640,
    parameter int ADDR_W      = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int BURST       = 4
) (
    input  logic                          clk_lcd,
    input  logic                          lcd_rst_n,
    input  logic                          sdr_addr_set,
    input  logic                          lcd_rden,
    output logic [95:0]                   lcd_data,
    output logic                          mem_rd_req,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic                          mem_rd_ack,
    input  logic                          mem_rd_valid,
    input  logic [95:0]                   mem_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_done,
    output logic                          underflow,
    output logic                          proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WL_W  = $clog2(FRAME_WORDS + 1);

    localparam logic [LVL_W-1:0]  BURST_L = LVL_W'(BURST);
    localparam logic [LVL_W-1:0]  ONE_L   = LVL_W'(1);
    localparam logic [LVL_W:0]    DEPTH_X = (LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [WL_W-1:0]   FRAME_L = WL_W'(FRAME_WORDS);
    localparam logic [WL_W-1:0]   BURST_W = WL_W'(BURST);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    state_t            state;
    logic [WL_W-1:0]   words_left;
    logic [LVL_W-1:0]  outstanding;
    logic [95:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W:0]    free;
    logic              push;
    logic              pop;
    logic              stray;
    logic              last_beat;

    // Credit: room left once every acked beat has landed.
    always_comb begin
        free      = DEPTH_X - {1'b0, fifo_level} - {1'b0, outstanding};
        push      = (state == WAIT) && mem_rd_valid && !sdr_addr_set;
        pop       = lcd_rden && (fifo_level != '0) && !sdr_addr_set;
        stray     = mem_rd_valid && (outstanding == '0)
                    && ((state == IDLE) || (state == REQ));
        last_beat = mem_rd_valid && (outstanding == ONE_L);
        lcd_data  = (fifo_level != '0) ? mem[rd_ptr] : '0;
    end

    // Request sequencer: issue bursts, track beats, rewind on restart.
    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            state       <= IDLE;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= BASE_L;
            words_left  <= FRAME_L;
            outstanding <= '0;
            frame_done  <= 1'b0;
        end else begin
            if (sdr_addr_set) begin
                mem_rd_addr <= BASE_L;
                words_left  <= FRAME_L;
                frame_done  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!sdr_addr_set) begin
                        if (words_left == '0) begin
                            frame_done <= 1'b1;
                        end else if (free >= {1'b0, BURST_L}) begin
                            state      <= REQ;
                            mem_rd_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_rd_ack) begin
                        mem_rd_req  <= 1'b0;
                        outstanding <= BURST_L;
                        if (sdr_addr_set) begin
                            state <= DRAIN;
                        end else begin
                            state       <= WAIT;
                            mem_rd_addr <= mem_rd_addr + BURST_A;
                            words_left  <= words_left - BURST_W;
                            frame_done  <= (words_left == BURST_W);
                        end
                    end else if (sdr_addr_set) begin
                        mem_rd_req <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WAIT, DRAIN: begin
                    if (mem_rd_valid) begin
                        outstanding <= outstanding - ONE_L;
                    end
                    if (last_beat) begin
                        state <= IDLE;
                    end else if (sdr_addr_set) begin
                        state <= DRAIN;
                    end
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            underflow  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (sdr_addr_set) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   fifo_level <= fifo_level + ONE_L;
                    2'b01:   fifo_level <= fifo_level - ONE_L;
                    default: fifo_level <= fifo_level;
                endcase
                if (lcd_rden && (fifo_level == '0)) begin
                    underflow <= 1'b1;
                end
            end
            if (stray) begin
                proto_err <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are masked by the level, so no reset.
    always_ff @(posedge clk_lcd) begin
        if (push) begin
            mem[wr_ptr] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader: directed scenarios with a queue-based model
// of the frame reader and a behavioural SDRAM responder.
module tb_lcd_frame_reader;

    localparam int BASE = 32'h100;
    localparam int FW   = 16;
    localparam int BL   = 4;

    logic        clk_lcd = 1'b0;
    logic        lcd_rst_n;
    logic        sdr_addr_set;
    logic        lcd_rden;
    logic [95:0] lcd_data;
    logic        mem_rd_req;
    logic [23:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [95:0] mem_rd_data;
    logic [3:0]  fifo_level;
    logic        frame_done;
    logic        underflow;
    logic        proto_err;

    lcd_frame_reader #(
        .BASE_ADDR  (BASE),
        .FRAME_WORDS(FW),
        .ADDR_W     (24),
        .FIFO_DEPTH (8),
        .BURST      (BL)
    ) dut (
        .clk_lcd     (clk_lcd),
        .lcd_rst_n   (lcd_rst_n),
        .sdr_addr_set(sdr_addr_set),
        .lcd_rden    (lcd_rden),
        .lcd_data    (lcd_data),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .fifo_level  (fifo_level),
        .frame_done  (frame_done),
        .underflow   (underflow),
        .proto_err   (proto_err)
    );

    always #5 clk_lcd = ~clk_lcd;

    typedef struct {
        int          at;
        logic [95:0] d;
    } beat_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc;
    int          ack_at;
    int          outst;
    int          discard;
    int          exp_words;
    logic [23:0] exp_addr;
    logic        exp_uf;
    logic        exp_pe;
    logic        req_q;
    logic [23:0] addr_q;
    logic [95:0] exp_q[$];
    logic [23:0] req_log[$];
    beat_t       sched[$];

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [95:0] rl(input int i);
        return (i < req_log.size()) ? 96'(req_log[i]) : '1;
    endfunction

    task automatic model_reset();
        cyc = 0; ack_at = -1; outst = 0; discard = 0;
        exp_words = FW; exp_addr = 24'(BASE);
        exp_uf = 0; exp_pe = 0; req_q = 0; addr_q = '0;
        exp_q.delete(); req_log.delete(); sched.delete();
        mem_rd_ack = 0; mem_rd_valid = 0; mem_rd_data = '0;
        lcd_rden = 0; sdr_addr_set = 0;
    endtask

    // One clock: sample what the DUT saw, update model, check, drive.
    task automatic step();
        logic        acc, beat, set_e, rden_e;
        logic [95:0] bdata;
        logic [23:0] addr_e;
        acc    = mem_rd_ack && req_q;
        addr_e = addr_q;
        beat   = mem_rd_valid;
        bdata  = mem_rd_data;
        set_e  = sdr_addr_set;
        rden_e = lcd_rden;
        @(posedge clk_lcd);
        #1;
        cyc++;
        if (acc) begin
            chk("req_addr", 96'(addr_e), 96'(exp_addr));
            req_log.push_back(addr_e);
            outst += BL;
            for (int i = 0; i < BL; i++)
                sched.push_back('{cyc + 3 + i, 96'(addr_e) + 96'(i)});
            if (!set_e) begin
                exp_addr  = exp_addr + 24'(BL);
                exp_words = exp_words - BL;
            end
            ack_at = -1;
        end
        if (set_e) begin
            exp_q.delete();
            discard   = outst;
            exp_addr  = 24'(BASE);
            exp_words = FW;
        end else if (rden_e) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else exp_uf = 1;
        end
        if (beat) begin
            if (outst == 0) exp_pe = 1;
            else begin
                outst--;
                if (discard > 0) discard--;
                else exp_q.push_back(bdata);
            end
        end
        chk("level", 96'(fifo_level), 96'(exp_q.size()));
        chk("head", lcd_data, (exp_q.size() > 0) ? exp_q[0] : '0);
        chk("underflow", 96'(underflow), 96'(exp_uf));
        chk("proto_err", 96'(proto_err), 96'(exp_pe));
        chk("req_after_end", 96'(mem_rd_req && exp_words == 0), 96'(0));
        if (set_e) begin
            chk("rewind_addr", 96'(mem_rd_addr), 96'(BASE));
            chk("rewind_done", 96'(frame_done), 96'(0));
        end
        lcd_rden = 0;
        sdr_addr_set = 0;
        if (!mem_rd_req) ack_at = -1;
        else if (ack_at < 0) ack_at = cyc + 2;
        mem_rd_ack = (ack_at == cyc + 1);
        req_q  = mem_rd_req;
        addr_q = mem_rd_addr;
        if (sched.size() > 0 && sched[0].at == cyc + 1) begin
            mem_rd_valid = 1;
            mem_rd_data  = sched[0].d;
            void'(sched.pop_front());
        end else begin
            mem_rd_valid = 0;
            mem_rd_data  = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_lcd);
        #1;
        lcd_rst_n = 0;
        model_reset();
        #1;
        chk("rst_req", 96'(mem_rd_req), 96'(0));
        chk("rst_addr", 96'(mem_rd_addr), 96'(BASE));
        chk("rst_level", 96'(fifo_level), 96'(0));
        chk("rst_data", lcd_data, 96'(0));
        chk("rst_flags", {frame_done, underflow, proto_err}, 96'(0));
        repeat (2) @(posedge clk_lcd);
        #1;
        lcd_rst_n = 1;
    endtask

    initial begin
        int          n;
        int          k;
        logic [95:0] head;
        logic [3:0]  lvl;
        lcd_rst_n = 0;
        model_reset();
        do_reset();

        // Fill with no pops: two bursts only.
        for (int i = 0; i < 80; i++) step();
        chk("t1_level", 96'(fifo_level), 96'(8));
        chk("t1_head", lcd_data, 96'(BASE));
        chk("t1_nreq", 96'(req_log.size()), 96'(2));
        chk("t1_req0", rl(0), 96'(BASE));
        chk("t1_req1", rl(1), 96'(BASE + 4));

        // Drain the whole frame, one pop every 4 cycles.
        for (k = 0; k < FW; k++) begin
            n = 0;
            while (exp_q.size() == 0 && n < 100) begin
                step();
                n++;
            end
            chk("t2_wait", 96'(n < 100), 96'(1));
            chk("t2_word", lcd_data, 96'(BASE + k));
            lcd_rden = 1;
            repeat (4) step();
        end
        repeat (20) step();
        chk("t2_done", 96'(frame_done), 96'(1));
        chk("t2_nreq", 96'(req_log.size()), 96'(4));
        chk("t2_req2", rl(2), 96'(BASE + 8));
        chk("t2_req3", rl(3), 96'(BASE + 12));
        chk("t2_uf", 96'(underflow), 96'(0));

        // Pop on empty right after reset.
        do_reset();
        lcd_rden = 1;
        step();
        chk("t5_uf", 96'(underflow), 96'(1));
        chk("t5_level", 96'(fifo_level), 96'(0));
        step();
        chk("t5_sticky", 96'(underflow), 96'(1));

        // Restart one cycle after the second ack.
        n = 0;
        while (req_log.size() < 2 && n < 200) begin
            step();
            n++;
        end
        chk("t3_wait", 96'(n < 200), 96'(1));
        sdr_addr_set = 1;
        step();
        repeat (6) step();
        chk("t3_flushed", 96'(fifo_level), 96'(0));
        k = req_log.size();
        n = 0;
        while (req_log.size() == k && n < 100) begin
            step();
            n++;
        end
        chk("t3_req", rl(k), 96'(BASE));
        n = 0;
        while (exp_q.size() == 0 && n < 100) begin
            step();
            n++;
        end
        chk("t3_first", lcd_data, 96'(BASE));

        // Restart in the same cycle as the ack at BASE+4.
        n = 0;
        while (!(mem_rd_ack && mem_rd_addr == 24'(BASE + 4)) && n < 200) begin
            step();
            n++;
        end
        chk("t4_wait", 96'(n < 200), 96'(1));
        sdr_addr_set = 1;
        step();
        chk("t4_addr", 96'(mem_rd_addr), 96'(BASE));
        k = req_log.size();
        n = 0;
        while (req_log.size() == k && n < 100) begin
            step();
            n++;
        end
        chk("t4_req", rl(k), 96'(BASE));
        chk("t4_discard", 96'(fifo_level), 96'(0));

        // Simultaneous push and pop at level 5.
        n = 0;
        while (!(fifo_level == 4'd5 && mem_rd_valid) && n < 100) begin
            step();
            n++;
        end
        chk("t6_wait", 96'(n < 100), 96'(1));
        head = lcd_data;
        lcd_rden = 1;
        step();
        chk("t6_level", 96'(fifo_level), 96'(5));
        chk("t6_head", lcd_data, head + 96'(1));

        // Stray beat while idle.
        n = 0;
        while (!(outst == 0 && !mem_rd_req) && n < 100) begin
            step();
            n++;
        end
        repeat (4) step();
        lvl = fifo_level;
        mem_rd_valid = 1;
        mem_rd_data  = 96'hdead;
        step();
        chk("t6_proto", 96'(proto_err), 96'(1));
        chk("t6_stray_level", 96'(fifo_level), 96'(lvl));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_frame_reader.md
Name: lcd_frame_reader

Overview:
- Prefetch stage directly upstream of the LCD timing/pixel driver.
- Walks a frame buffer in SDRAM as 96-bit words (4 pixels each) using burst read requests, and holds them in a first-word-fall-through FIFO.
- Presents the FIFO head on lcd_data and pops one word per lcd_rden pulse.
- Restarts at the frame base address on every sdr_addr_set pulse from the driver.

Parameters:
- BASE_ADDR, 0: word address of the first 96-bit word of the frame.
- FRAME_WORDS, 32640: 96-bit words per frame (480*272/4). Must be a multiple of BURST.
- ADDR_W, 24: width of mem_rd_addr.
- FIFO_DEPTH, 8: FIFO entries. Power of two, at least 2*BURST.
- BURST, 4: 96-bit beats per memory read request.

Ports:
- clk_lcd  in  1  pixel clock; all logic on its rising edge.
- lcd_rst_n  in  1  asynchronous, active-low reset.
- sdr_addr_set  in  1  one-cycle pulse: restart frame (flush and rewind).
- lcd_rden  in  1  one-cycle pop of the FIFO head.
- lcd_data  out  96  FIFO head word; 0 when FIFO empty.
- mem_rd_req  out  1  burst read request; held until acked.
- mem_rd_addr  out  ADDR_W  start word address of the requested burst.
- mem_rd_ack  in  1  request accepted; BURST beats will follow.
- mem_rd_valid  in  1  one returned beat.
- mem_rd_data  in  96  returned beat data.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_done  out  1  high once all FRAME_WORDS requested; cleared by sdr_addr_set.
- underflow  out  1  sticky: lcd_rden seen with FIFO empty.
- proto_err  out  1  sticky: mem_rd_valid seen with no beat outstanding.

Behaviour:
- Reset (lcd_rst_n=0, async):
  - mem_rd_req=0, mem_rd_addr=BASE_ADDR, fifo_level=0, lcd_data=0.
  - frame_done=0, underflow=0, proto_err=0.
  - words_left=FRAME_WORDS, FSM=IDLE.
  - Reset mid-burst abandons the burst; any beats arriving after release count as proto_err.
- FIFO:
  - FWFT: lcd_data shows the head combinationally from storage.
  - Push on mem_rd_valid in WAIT; pop on lcd_rden when level>0.
  - Push and pop in the same cycle leave the level unchanged.
  - Pop on empty: no state change; underflow sets.
  - Credit scheme guarantees no push when full.
- Credit: free = FIFO_DEPTH - fifo_level - outstanding, where outstanding = beats acked but not yet received.
- FSM states IDLE, REQ, WAIT, DRAIN:
  - IDLE -> REQ when free>=BURST, words_left>0 and no sdr_addr_set this cycle.
  - REQ: mem_rd_req=1 and mem_rd_addr stable. On mem_rd_ack: mem_rd_addr+=BURST, words_left-=BURST, outstanding+=BURST, then go to WAIT. Request rises the cycle after the IDLE decision.
  - WAIT: each mem_rd_valid pushes and decrements outstanding. After the BURST-th beat go to IDLE; the next REQ can start one cycle later.
  - DRAIN: beats are consumed and discarded, not pushed. When outstanding reaches 0 go to IDLE.
- sdr_addr_set, any state:
  - Next cycle: FIFO flushed (level=0, lcd_data=0), mem_rd_addr=BASE_ADDR, words_left=FRAME_WORDS, frame_done=0.
  - In REQ with no ack in the same cycle: drop mem_rd_req and go to IDLE.
  - In REQ with ack in the same cycle: the burst counts as accepted; go to DRAIN with outstanding=BURST.
  - In WAIT: go to DRAIN. A beat in the same cycle is discarded.
  - A lcd_rden in the same cycle is ignored and does not set underflow.
- End of frame: when words_left=0 and FSM=IDLE, frame_done=1. No further requests and no address wrap until sdr_addr_set.
- mem_rd_valid in IDLE or REQ with outstanding=0: beat ignored; proto_err sets.
- Address arithmetic is modulo 2^ADDR_W.

Test Plan:
(Bench parameters: FRAME_WORDS=16, FIFO_DEPTH=8, BURST=4, BASE_ADDR=0x100. Memory model acks 2 cycles after req and returns beats back-to-back 3 cycles after ack, data = address.)
1. Release reset, no pops -> mem_rd_req issued at 0x100 then 0x104 only. fifo_level settles at 8; lcd_data=0x100.
2. Pop 16 words spread one per 4 cycles -> lcd_data sequence 0x100..0x10F in order. Requests go to 0x108 and 0x10C. frame_done=1 after the ack at 0x10C; no request at 0x110. underflow=0.
3. sdr_addr_set pulsed 1 cycle after the ack at 0x104, before any beat -> FSM enters DRAIN. The 4 beats are discarded and fifo_level=0. The next request is at 0x100 and the first word presented is 0x100.
4. sdr_addr_set in the same cycle as mem_rd_ack -> mem_rd_addr=0x100 next cycle. The 4 beats are discarded and the following request is at 0x100.
5. lcd_rden with FIFO empty after reset -> underflow=1 and stays 1. fifo_level stays 0 and the FIFO is otherwise unaffected.
6. Push and pop in the same cycle at fifo_level=5 -> level stays 5 and the head advances one word. A stray mem_rd_valid in IDLE sets proto_err=1 and fifo_level is unchanged.
